// File: rtl/pe_array_feeder_if.sv
// rtl/pe_array_feeder_if.sv - job, input-stream and PE-edge signals of the array feeder
interface pe_array_feeder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int K_WIDTH    = 8
);
    logic                       start;
    logic [K_WIDTH-1:0]         k_len;
    logic [COLS*DATA_WIDTH-1:0] w_data;
    logic                       s_valid;
    logic                       s_ready;
    logic [ROWS*DATA_WIDTH-1:0] s_data;
    logic [ROWS*DATA_WIDTH-1:0] left_data;
    logic [ROWS-1:0]            left_valid;
    logic [COLS*DATA_WIDTH-1:0] top_data;
    logic                       load_weight;
    logic                       clear_acc;
    logic                       enable;
    logic                       acc_enable;
    logic                       busy;
    logic                       done;

    // Job source / vector producer side
    modport master (
        output start, k_len, w_data, s_valid, s_data,
        input  s_ready, left_data, left_valid, top_data, load_weight,
               clear_acc, enable, acc_enable, busy, done
    );

    // Feeder side
    modport slave (
        input  start, k_len, w_data, s_valid, s_data,
        output s_ready, left_data, left_valid, top_data, load_weight,
               clear_acc, enable, acc_enable, busy, done
    );
endinterface

// File: rtl/pe_array_feeder.sv
// rtl/pe_array_feeder.sv - sequences clear, weight load, skewed streaming and drain for a systolic PE array
module pe_array_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int K_WIDTH    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pe_array_feeder_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LOADW  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    // The last skewed lane leaves the array ROWS+COLS-1 cycles after the last vector enters
    localparam int          DRAIN_LEN  = ROWS + COLS - 1;
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_LEN - 1);

    state_t                     state_q, state_d;
    logic [K_WIDTH-1:0]         k_len_q, k_len_d;
    logic [COLS*DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [15:0]                remain_q, remain_d;
    logic [15:0]                drain_q, drain_d;
    logic [COLS*DATA_WIDTH-1:0] top_data_q, top_data_d;
    logic                       s_ready_q, s_ready_d;
    logic                       clear_acc_q, clear_acc_d;
    logic                       load_weight_q, load_weight_d;
    logic                       enable_q, enable_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       accept;

    // s_ready is registered high only in STREAM, so it alone qualifies the handshake
    assign accept = s_ready_q & bus.s_valid;

    // Next state, job capture and counters; the registered outputs are decoded from the next state
    always_comb begin
        state_d  = state_q;
        k_len_d  = k_len_q;
        w_data_d = w_data_q;
        remain_d = remain_q;
        drain_d  = drain_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    k_len_d  = bus.k_len;
                    w_data_d = bus.w_data;
                    state_d  = CLEAR;
                end
            end
            CLEAR: state_d = LOADW;
            LOADW: begin
                remain_d = 16'(k_len_q);
                state_d  = (k_len_q == '0) ? DONE : STREAM;
            end
            STREAM: begin
                if (accept) begin
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LAST;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        s_ready_d     = (state_d == STREAM);
        clear_acc_d   = (state_d == CLEAR);
        load_weight_d = (state_d == LOADW);
        top_data_d    = (state_d == LOADW) ? w_data_d : '0;
        enable_d      = (state_d == STREAM) || (state_d == DRAIN);
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
    end

    // FSM state, captured job parameters, counters and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            k_len_q       <= '0;
            w_data_q      <= '0;
            remain_q      <= '0;
            drain_q       <= '0;
            top_data_q    <= '0;
            s_ready_q     <= 1'b0;
            clear_acc_q   <= 1'b0;
            load_weight_q <= 1'b0;
            enable_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_len_q       <= k_len_d;
            w_data_q      <= w_data_d;
            remain_q      <= remain_d;
            drain_q       <= drain_d;
            top_data_q    <= top_data_d;
            s_ready_q     <= s_ready_d;
            clear_acc_q   <= clear_acc_d;
            load_weight_q <= load_weight_d;
            enable_q      <= enable_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.clear_acc   = clear_acc_q;
    assign bus.load_weight = load_weight_q;
    assign bus.top_data    = top_data_q;
    assign bus.enable      = enable_q;
    assign bus.acc_enable  = enable_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

    // Lane r is delayed by r+1 stages so row r meets the wavefront one cycle after row r-1
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [(r+1)*DATA_WIDTH-1:0] chain_q, chain_d;
        logic [r:0]                  vld_q, vld_d;

        // Shift one stage per cycle; cycles without a handshake inject a zero bubble
        always_comb begin
            chain_d                   = chain_q << DATA_WIDTH;
            vld_d                     = vld_q << 1;
            chain_d[DATA_WIDTH-1:0]   = accept ? bus.s_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
            vld_d[0]                  = accept;
        end

        // Skew stage registers for this lane
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain_q <= '0;
                vld_q   <= '0;
            end else begin
                chain_q <= chain_d;
                vld_q   <= vld_d;
            end
        end

        assign bus.left_data[r*DATA_WIDTH +: DATA_WIDTH] = chain_q[r*DATA_WIDTH +: DATA_WIDTH];
        assign bus.left_valid[r]                         = vld_q[r];
    end
endmodule

// File: doc/pe_array_feeder.md
Name: pe_array_feeder

Overview:
- Drives the left and top edges of a ROWS x COLS systolic PE array, acting as the sequencer on the far side of the PE edge interface.
- Per job, it pulses clear_acc, then loads one weight per column through the top edge with load_weight.
- It then accepts k_len input vectors over a valid/ready stream and emits them diagonally skewed on the left edge, holding enable/acc_enable high.
- It finishes with a drain period and a done pulse.

Parameters:
- DATA_WIDTH, 16, width of each lane / weight
- ROWS, 4, number of array rows (left-edge lanes)
- COLS, 4, number of array columns (top-edge lanes)
- K_WIDTH, 8, width of the vector-count field

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  job start request, sampled only in IDLE
- k_len  input  K_WIDTH  number of input vectors in this job, captured on accepted start
- w_data  input  COLS*DATA_WIDTH  per-column weights, lane c at bits [c*DATA_WIDTH +: DATA_WIDTH], captured on accepted start
- s_valid  input  1  input vector valid
- s_ready  output  1  feeder can accept a vector
- s_data  input  ROWS*DATA_WIDTH  input vector, lane r = row r
- left_data  output  ROWS*DATA_WIDTH  skewed row data to array in_left
- left_valid  output  ROWS  per-row flag that the lane carries real data, not a bubble
- top_data  output  COLS*DATA_WIDTH  to array in_top (weights)
- load_weight  output  1  weight load strobe
- clear_acc  output  1  accumulator clear strobe
- enable  output  1  PE enable
- acc_enable  output  1  PE accumulate enable
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle job-complete pulse

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; skew registers and captured k_len/w_data cleared. Reset mid-job aborts immediately; no done pulse is produced.
- All outputs are registered.
- States: IDLE, CLEAR, LOADW, STREAM, DRAIN, DONE.
- IDLE:
  - s_ready = 0.
  - start = 1 captures k_len and w_data, then -> CLEAR next cycle.
  - start in any other state is ignored.
- CLEAR (1 cycle): clear_acc = 1, then -> LOADW.
- LOADW (1 cycle):
  - load_weight = 1; top_data = captured w_data.
  - If k_len == 0 -> DONE, otherwise -> STREAM.
  - top_data is 0 in all other states.
- STREAM:
  - s_ready = 1; enable = acc_enable = 1.
  - A vector is accepted when s_valid && s_ready.
  - A 16-bit remaining-count is loaded with k_len and decrements per accepted vector.
  - When the k_len-th vector is accepted, s_ready drops the next cycle and the FSM -> DRAIN.
  - A cycle with s_valid = 0 inserts a bubble: zero data, valid bit 0. enable stays 1 during bubbles.
- Skew:
  - Lane r of an item accepted at cycle t appears on left_data/left_valid at cycle t+1+r.
  - Implementation: per-lane shift chain of depth r+1; lane 0 is a single register.
  - Bubbles and the DRAIN/idle periods shift in zeros with valid 0.
- DRAIN:
  - Lasts exactly ROWS+COLS-1 cycles, counted from the first cycle in DRAIN.
  - enable = acc_enable = 1; no input is accepted.
  - Then -> DONE.
- DONE (1 cycle): done = 1, enable = acc_enable = 0, busy = 1, then -> IDLE.
- No arithmetic on data; values pass through bit-exact, including negative two's-complement values.
- Boundary cases:
  - k_len = max (2^K_WIDTH-1) must stream fully without counter wrap.
  - Back-to-back jobs are allowed: start asserted in the cycle after DONE is accepted.
  - s_valid held high across the STREAM->DRAIN boundary: only k_len vectors are consumed.

Test Plan:
- Reset: assert rst_n = 0 with random inputs -> all outputs 0, busy = 0; release -> still IDLE, s_ready = 0.
- Basic job, ROWS = COLS = 4, w_data = {4,3,2,1}, k_len = 2, vectors {10,11,12,13} then {20,21,22,23}, s_valid continuous ->
  - clear_acc high 1 cycle; then load_weight high 1 cycle with top_data = {4,3,2,1}.
  - Lane 0 shows 10,20 one cycle after acceptance; lane 3 shows 13,23 four cycles after acceptance.
  - Drain is 7 cycles; done pulses once; exactly 2 handshakes occur.
- Bubble insertion: k_len = 3 with s_valid low for 2 cycles between vectors 1 and 2 -> zeros with left_valid = 0 appear skewed on every lane; enable stays 1; the three vectors arrive intact.
- Signed passthrough: s_data lanes = -5, -3 (0xFFFB, 0xFFFD) and weight -5 -> left_data/top_data bit-exact.
- k_len = 0 -> CLEAR, LOADW, DONE in 3 cycles; no s_ready; enable never asserted.
- Abort and busy handling:
  - rst_n low mid-STREAM -> all outputs 0 asynchronously, no done pulse; a new start after release runs a full clean job.
  - start pulsed while busy -> ignored; job length unchanged.
